trx_scheduler: RTL and testbench
================================

TRX_SCHEDULER -- requirements
Module: trx_scheduler

Interface
REQ-001 Parameter SAMPLE_NUMBER, default 256, samples per carrier period (power of two, >=4).
REQ-002 Parameter DATA_WIDTH, default 12, Hamming codeword width (symbols per frame).
REQ-003 Parameter FIFO_DEPTH, default 4, byte queue depth (power of two, >=2).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 rx_dv  input  1  one-cycle strobe: rx_byte valid from UART receiver.
REQ-007 rx_byte  input  8  received byte.
REQ-008 tx_active  input  1  UART transmitter busy.
REQ-009 tx_done  input  1  one-cycle strobe: UART byte transmission finished.
REQ-010 enc_wren  output  1  one-cycle load strobe to Hamming encoder.
REQ-011 enc_data  output  8  byte to encoder, valid while enc_wren high.
REQ-012 mod_en  output  1  enable for sine generator, modulator, demodulator.
REQ-013 dec_rden  output  1  one-cycle read strobe to Hamming decoder.
REQ-014 tx_dv  output  1  one-cycle start strobe to UART transmitter.
REQ-015 busy  output  1  high whenever state is not IDLE or FIFO non-empty.
REQ-016 overflow  output  1  one-cycle pulse when a byte is dropped.
REQ-017 drop_cnt  output  8  dropped-byte count (see Configuration).

Function
REQ-018 Byte queue SHALL be a FIFO_DEPTH-entry FIFO; rx_dv pushes rx_byte unless full.
REQ-019 rx_dv while full and no pop that cycle SHALL drop the byte and pulse overflow the next cycle; with simultaneous pop the push SHALL be accepted.
REQ-020 FSM states: IDLE, LOAD, SEND, DECODE, SETTLE, WAIT_TX, WAIT_DONE.
REQ-021 IDLE -> LOAD when FIFO non-empty; a byte pushed in cycle N reaches LOAD in cycle N+2 from an empty IDLE.
REQ-022 LOAD (1 cycle): enc_wren=1, enc_data=FIFO head, FIFO pops; -> SEND.
REQ-023 SEND: mod_en=1 for exactly SAMPLE_NUMBER*DATA_WIDTH cycles, tracked by a log2(SAMPLE_NUMBER) sample counter wrapping into a bit counter 0..DATA_WIDTH-1; -> DECODE after sample counter wraps with bit counter = DATA_WIDTH-1.
REQ-024 DECODE (1 cycle): dec_rden=1, mod_en=0; -> SETTLE.
REQ-025 SETTLE (1 cycle): no strobes; -> WAIT_TX.
REQ-026 WAIT_TX: while tx_active=1 hold; when tx_active=0 assert tx_dv one cycle -> WAIT_DONE.
REQ-027 WAIT_DONE: hold until tx_done=1 -> IDLE; bytes arriving meanwhile SHALL queue normally.
REQ-028 Counters SHALL clear on entry to SEND; mod_en SHALL be 0 in every state except SEND.
REQ-029 enc_wren, dec_rden, tx_dv SHALL never be high in the same cycle.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, empty FIFO, counters 0, all outputs 0 (drop_cnt 0), including mid-SEND.
REQ-031 After rst_n deassertion, first action SHALL occur only on a new rx_dv.

Configuration
REQ-032 Macro TRX_SCHEDULER_DROP_CNT_EN defined: drop_cnt increments on each overflow pulse, saturates at 255, cleared only by reset.
REQ-033 Macro undefined: drop_cnt tied to 0, no counter logic; overflow unaffected.

Verification
REQ-034 Reset, rx_dv with 0xA5 at cycle 10 -> enc_wren at 12 with enc_data=0xA5, mod_en high cycles 13..3084, dec_rden at 3085, tx_dv at 3087 (tx_active=0).
REQ-035 Five rx_dv back-to-back (0x01..0x05) during SEND, depth 4 -> 0x05 dropped, overflow one pulse, drop_cnt=1 with macro, 0 without; 0x01..0x04 transmitted in order.
REQ-036 tx_active held high 100 cycles after SETTLE -> tx_dv asserted exactly one cycle after tx_active falls.
REQ-037 rst_n pulled low mid-SEND (cycle 500 of frame) -> mod_en, busy drop at once; FIFO empty; no tx_dv after release.
REQ-038 FIFO full with LOAD pop and rx_dv same cycle -> byte accepted, no overflow.
REQ-039 300 dropped bytes with macro -> drop_cnt saturates at 255.

Source files
------------

// File: rtl/trx_scheduler.sv
// ============================================================================
// trx_scheduler
//   Sequences one byte at a time through the modem chain:
//   queue byte -> load Hamming encoder -> run the modulator for one full
//   codeword (SAMPLE_NUMBER * DATA_WIDTH cycles) -> read the Hamming decoder
//   -> hand the decoded byte to the UART transmitter and wait for completion.
//
// Parameters
//   SAMPLE_NUMBER  samples per carrier period (power of two, >= 4)
//   DATA_WIDTH     Hamming codeword width in symbols
//   FIFO_DEPTH     byte queue depth (power of two, >= 2)
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   rx_dv/rx_byte  byte strobe + data from the UART receiver
//   tx_active      UART transmitter busy
//   tx_done        UART transmitter finished a byte (strobe)
//   enc_wren/enc_data  encoder load strobe + byte
//   mod_en         sine generator / modulator / demodulator enable
//   dec_rden       decoder read strobe
//   tx_dv          UART transmit start strobe
//   busy           FSM not idle or queue not empty
//   overflow       one-cycle pulse when an incoming byte was dropped
//   drop_cnt       saturating dropped-byte count
//
// Build option
//   TRX_SCHEDULER_DROP_CNT_EN  when defined, drop_cnt counts overflow pulses
//                              (saturating at 255); otherwise it is tied to 0.
// ============================================================================
module trx_scheduler #(
    parameter int SAMPLE_NUMBER = 256,
    parameter int DATA_WIDTH    = 12,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic       enc_wren,
    output logic [7:0] enc_data,
    output logic       mod_en,
    output logic       dec_rden,
    output logic       tx_dv,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] drop_cnt
);

    localparam int SW = $clog2(SAMPLE_NUMBER);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        DECODE,
        SETTLE,
        WAIT_TX,
        WAIT_DONE
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Byte queue: pointers carry one extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, fifo_pop, fifo_push, drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // LOAD is only entered with a non-empty queue, so it always pops.
    assign fifo_pop   = (state == LOAD);
    // A pop in the same cycle frees the slot, so a push into a full queue
    // is still accepted then.
    assign fifo_push  = rx_dv && (!fifo_full || fifo_pop);
    assign drop       = rx_dv && fifo_full && !fifo_pop;

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            overflow <= drop;
        end
    end

    // ------------------------------------------------------------------
    // Frame timing: sample counter wraps into the symbol (bit) counter.
    // ------------------------------------------------------------------
    logic [SW-1:0] sample_cnt;
    logic [BW-1:0] bit_cnt;
    logic          frame_end;

    assign frame_end = (sample_cnt == '1) && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == LOAD) begin
                sample_cnt <= '0;
                bit_cnt    <= '0;
            end else if (state == SEND) begin
                sample_cnt <= sample_cnt + SW'(1);
                if (sample_cnt == '1) begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        enc_wren  = 1'b0;
        enc_data  = '0;
        mod_en    = 1'b0;
        dec_rden  = 1'b0;
        tx_dv     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = LOAD;
            end
            LOAD: begin
                enc_wren  = 1'b1;
                enc_data  = fifo_mem[rd_ptr[AW-1:0]];
                state_nxt = SEND;
            end
            SEND: begin
                mod_en = 1'b1;
                if (frame_end) state_nxt = DECODE;
            end
            DECODE: begin
                dec_rden  = 1'b1;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (!tx_active) begin
                    tx_dv     = 1'b1;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE) || !fifo_empty;

`ifdef TRX_SCHEDULER_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (overflow && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_trx_scheduler.sv
// Self-checking bench for trx_scheduler (default parameters).
module tb_trx_scheduler;

    localparam int SN        = 256;
    localparam int DW        = 12;
    localparam int FD        = 4;
    localparam int FRAME_LEN = SN * DW;

`ifdef TRX_SCHEDULER_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       rx_dv     = 1'b0;
    logic [7:0] rx_byte   = 8'h00;
    logic       tx_active = 1'b0;
    logic       tx_done;
    logic       enc_wren, mod_en, dec_rden, tx_dv, busy, overflow;
    logic [7:0] enc_data, drop_cnt;

    trx_scheduler #(
        .SAMPLE_NUMBER(SN),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_dv    (rx_dv),
        .rx_byte  (rx_byte),
        .tx_active(tx_active),
        .tx_done  (tx_done),
        .enc_wren (enc_wren),
        .enc_data (enc_data),
        .mod_en   (mod_en),
        .dec_rden (dec_rden),
        .tx_dv    (tx_dv),
        .busy     (busy),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model: a byte queue plus frame timing measured as an offset
    // from the cycle the byte was loaded.
    // ------------------------------------------------------------------
    logic [7:0] m_q[$];
    bit m_frame, m_wtx, m_wdone, m_ovf_pend, m_mod, m_busy;
    int m_load, m_drops;

    // Scoreboard queues: one entry per strobe expected in the current cycle.
    logic [7:0] enc_q[$];
    int dec_q[$], tx_q[$], ovf_q[$];

    task automatic model_eval();
        int off;
        bit pop, nonempty;
        off    = cyc - m_load;
        pop    = m_frame && (off == 0);
        m_mod  = m_frame && (off >= 1) && (off <= FRAME_LEN);
        m_busy = m_frame || m_wtx || m_wdone || (m_q.size() > 0);
        if (pop) enc_q.push_back(m_q[0]);
        if (m_frame && off == FRAME_LEN + 1) dec_q.push_back(cyc);
        if (m_wtx && !tx_active) tx_q.push_back(cyc);
        if (m_ovf_pend) ovf_q.push_back(cyc);

        nonempty = (m_q.size() > 0);
        if (pop) void'(m_q.pop_front());
        m_ovf_pend = 1'b0;
        if (rx_dv) begin
            if (m_q.size() < FD) m_q.push_back(rx_byte);
            else begin
                m_ovf_pend = 1'b1;
                m_drops++;
            end
        end
        if (m_wdone) begin
            if (tx_done) m_wdone = 1'b0;
        end else if (m_wtx) begin
            if (!tx_active) begin m_wtx = 1'b0; m_wdone = 1'b1; end
        end else if (m_frame) begin
            if (off == FRAME_LEN + 2) begin m_frame = 1'b0; m_wtx = 1'b1; end
        end else if (nonempty) begin
            m_frame = 1'b1;
            m_load  = cyc + 1;
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            m_q.delete();
            enc_q.delete(); dec_q.delete(); tx_q.delete(); ovf_q.delete();
            m_frame = 0; m_wtx = 0; m_wdone = 0; m_ovf_pend = 0;
            m_mod = 0; m_busy = 0; m_drops = 0; m_load = 0;
        end else begin
            model_eval();
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [7:0] seen[$];
    int ovf_seen = 0, tx_seen = 0;
    int rec_enc = 0, rec_mod_rise = 0, rec_mod_last = 0, rec_dec = 0, rec_tx = 0;
    bit prev_mod = 0;

    always @(negedge clk) begin
        logic [7:0] d;
        bit e;
        check("mod_en", mod_en, m_mod);
        check("busy", busy, m_busy);

        e = enc_q.size() > 0;
        check("enc_wren", enc_wren, e);
        if (e) begin
            d = enc_q.pop_front();
            if (enc_wren === 1'b1) check("enc_data", enc_data, d);
        end
        if (enc_wren === 1'b1) begin seen.push_back(enc_data); rec_enc = cyc; end

        e = dec_q.size() > 0;
        check("dec_rden", dec_rden, e);
        if (e) void'(dec_q.pop_front());
        if (dec_rden === 1'b1) rec_dec = cyc;

        e = tx_q.size() > 0;
        check("tx_dv", tx_dv, e);
        if (e) void'(tx_q.pop_front());
        if (tx_dv === 1'b1) begin rec_tx = cyc; tx_seen++; end

        e = ovf_q.size() > 0;
        check("overflow", overflow, e);
        if (e) void'(ovf_q.pop_front());
        if (overflow === 1'b1) ovf_seen++;

        if ((enc_wren | dec_rden | tx_dv) === 1'b1)
            check("strobe_onehot", int'(enc_wren) + int'(dec_rden) + int'(tx_dv), 1);

        if (!rst_n) begin
            check("rst_enc_data", enc_data, 0);
            check("rst_drop_cnt", drop_cnt, 0);
            check("rst_overflow", overflow, 0);
        end

        if (mod_en === 1'b1 && !prev_mod) rec_mod_rise = cyc;
        if (mod_en === 1'b1) rec_mod_last = cyc;
        prev_mod = (mod_en === 1'b1);
    end

    // UART transmitter stand-in: finishes each started byte a few cycles later.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_dv === 1'b1) begin
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b, output int t);
        @(posedge clk); #1;
        rx_dv = 1'b1; rx_byte = b; t = cyc;
        @(posedge clk); #1;
        rx_dv = 1'b0;
    endtask

    function automatic logic sig_of(input int w);
        case (w)
            0:       return mod_en;
            1:       return dec_rden;
            default: return enc_wren;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int limit, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sig_of(which) !== 1'b1 && n < limit);
        check(name, sig_of(which) === 1'b1, 1);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        repeat (2) @(negedge clk);
        while ((busy !== 1'b0 || m_busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, busy === 1'b0, 1);
    endtask

    logic [7:0] exp35 [5] = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04};

    initial begin
        int t0, tfall, tx_before, burst;
        bit hit;

        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single byte: absolute frame timing.
        seen.delete();
        repeat (9) @(posedge clk);
        send_byte(8'hA5, t0);
        wait_idle(5000, "frame1_done");
        check("t_enc_wren", rec_enc - t0, 2);
        check("t_mod_first", rec_mod_rise - t0, 3);
        check("t_mod_last", rec_mod_last - t0, FRAME_LEN + 2);
        check("t_dec_rden", rec_dec - t0, FRAME_LEN + 3);
        check("t_tx_dv", rec_tx - t0, FRAME_LEN + 5);
        check("frame1_count", seen.size(), 1);
        if (seen.size() > 0) check("frame1_byte", seen[0], 8'hA5);

        // Five back-to-back bytes while the queue's only slot holder is sending.
        seen.delete();
        ovf_seen = 0;
        send_byte(8'hAA, t0);
        wait_sig(0, 100, "wait_send2");
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            rx_dv = 1'b1; rx_byte = 8'(i);
        end
        @(posedge clk); #1 rx_dv = 1'b0;
        wait_idle(20000, "burst_done");
        check("burst_count", seen.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < seen.size()) check("burst_order", seen[i], exp35[i]);
        check("burst_overflow_pulses", ovf_seen, 1);
        check("burst_drop_cnt", drop_cnt, DROP_EN ? 1 : 0);

        // Transmitter busy for 100 cycles after SETTLE.
        tx_before = tx_seen;
        send_byte(8'h3C, t0);
        wait_sig(1, 5000, "wait_decode3");
        @(posedge clk); #1 tx_active = 1'b1;
        repeat (101) @(posedge clk);
        #1 tx_active = 1'b0;
        tfall = cyc;
        wait_idle(200, "frame3_done");
        check("tx_dv_first_idle_cycle", rec_tx - tfall, 0);
        check("tx_dv_once", tx_seen - tx_before, 1);

        // Flood a full queue across the next LOAD, then reset mid-SEND.
        send_byte(8'h5A, t0);
        wait_sig(0, 100, "wait_send4");
        hit = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            rx_dv = 1'b1; rx_byte = 8'(i);
            @(negedge clk);
            if (enc_wren === 1'b1) begin hit = 1; break; end
        end
        @(posedge clk); #1 rx_dv = 1'b0;
        @(negedge clk);
        check("load_push_no_overflow", overflow, 0);
        check("flood_reached_load", hit, 1);
        repeat (3) @(negedge clk);
        check("drop_cnt_saturated", drop_cnt, DROP_EN ? 255 : 0);

        repeat (497) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("reset_mod_en_now", mod_en, 0);
        check("reset_busy_now", busy, 0);
        check("reset_drop_cnt_now", drop_cnt, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tx_before = tx_seen;
        repeat (3200) @(posedge clk);
        check("no_tx_after_reset", tx_seen - tx_before, 0);
        check("idle_after_reset", busy, 0);

        // Random traffic with random transmitter back-pressure.
        burst = 0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            if (burst == 0 && $urandom_range(0, 1499) == 0) burst = $urandom_range(1, 6);
            if (burst > 0) begin
                rx_dv = 1'b1; rx_byte = 8'($urandom); burst--;
            end else begin
                rx_dv = 1'b0;
            end
            if ($urandom_range(0, 29) == 0) tx_active = ~tx_active;
        end
        @(posedge clk); #1;
        rx_dv = 1'b0; tx_active = 1'b0;
        wait_idle(20000, "random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
